// File: rtl/bcd_serial_subtractor.sv
// ---------------------------------------------------------------------------
// bcd_serial_subtractor
//
// Purpose:
//   Subtracts two packed-BCD numbers (A - B) one digit per clock cycle.
//   It returns the magnitude |A - B| and a sign flag.
//
//   The SUB pass computes A + (10^N - 1 - B) + 1 digit by digit, using the
//   nine's complement of B plus an initial carry of one. A final carry of
//   one means A >= B, and the stored digits are already the answer.
//
//   A final carry of zero means A < B. The stored digits then hold
//   10^N - |A - B|. A FIX pass ten's-complements them back into the
//   magnitude.
//
//   Operands containing a non-decimal digit are rejected at capture time.
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - capture a/b and begin; only looked at while idle
//   a, b    - minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy    - high whenever the FSM is not idle
//   done    - one-cycle completion pulse
//   result  - |A - B| in packed BCD (valid when done is high)
//   neg     - high when A < B
//   invalid - high when a captured digit was greater than 9
// ---------------------------------------------------------------------------
module bcd_serial_subtractor #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [4*N-1:0] a,
  input  logic [4*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] result,
  output logic           neg,
  output logic           invalid
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [4*N-1:0] a_reg, b_reg, res_reg, res_upd;
  logic [IDXW-1:0] idx;
  logic carry, neg_reg, invalid_reg, done_reg;
  logic [3:0] a_dig, b_dig, r_dig, dig_out;
  logic [4:0] sum;
  logic carry_out, last_digit, start_bad;

  // True if any nibble of the packed operand is not a decimal digit.
  function automatic logic has_bad_digit(input logic [4*N-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign start_bad  = has_bad_digit(a) | has_bad_digit(b);
  assign last_digit = (idx == IDXW'(N - 1));

  // Pick out the digit currently being worked on from each register.
  // A mux loop keeps every index in range for any N.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    r_dig = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDXW'(i)) begin
        a_dig = a_reg[i*4 +: 4];
        b_dig = b_reg[i*4 +: 4];
        r_dig = res_reg[i*4 +: 4];
      end
    end
  end

  // One decimal digit step, shared by both passes.
  //   SUB: a_d + (9 - b_d) + c
  //   FIX: (9 - r_d) + c
  // Both use the same "above nine -> subtract ten, carry out" correction.
  always_comb begin
    if (state == FIX) begin
      sum = (5'd9 - {1'b0, r_dig}) + {4'd0, carry};
    end else begin
      sum = {1'b0, a_dig} + (5'd9 - {1'b0, b_dig}) + {4'd0, carry};
    end
    if (sum > 5'd9) begin
      dig_out   = 4'(sum - 5'd10);
      carry_out = 1'b1;
    end else begin
      dig_out   = sum[3:0];
      carry_out = 1'b0;
    end
  end

  // Copy of the result register with the current digit replaced.
  // This is what gets written back in both SUB and FIX.
  always_comb begin
    res_upd = res_reg;
    for (int i = 0; i < N; i++) begin
      if (idx == IDXW'(i)) res_upd[i*4 +: 4] = dig_out;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // Bad operands skip straight to DONE. A SUB pass with no final carry
  // (A < B) detours through FIX before finishing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = start_bad ? DONE : SUB;
      SUB:  if (last_digit) state_next = carry_out ? DONE : FIX;
      FIX:  if (last_digit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: operands, result digits, carry, digit index and
  // the sticky flags.
  //
  // done is registered from the DONE state, so the pulse shows up on the
  // edge that returns the FSM to IDLE. A new start can therefore be
  // presented while done is still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      idx         <= '0;
      carry       <= 1'b0;
      neg_reg     <= 1'b0;
      invalid_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg       <= a;
            b_reg       <= b;
            res_reg     <= '0;
            idx         <= '0;
            carry       <= 1'b1;
            neg_reg     <= 1'b0;
            invalid_reg <= start_bad;
          end
        end
        SUB: begin
          res_reg <= res_upd;
          carry   <= carry_out;
          if (last_digit) begin
            idx <= '0;
            if (!carry_out) begin
              neg_reg <= 1'b1;
              carry   <= 1'b1;
            end
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        FIX: begin
          res_reg <= res_upd;
          carry   <= carry_out;
          if (last_digit) idx <= '0;
          else            idx <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_reg;
  assign result  = res_reg;
  assign neg     = neg_reg;
  assign invalid = invalid_reg;

endmodule

// File: doc/bcd_serial_subtractor.md
BCD_SERIAL_SUBTRACTOR -- requirements
Module: bcd_serial_subtractor

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of BCD digits per operand (N >= 1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to capture a and b and begin A - B.
REQ-005 SHALL have port a, input, 4N bits: minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port b, input, 4N bits: subtrahend, packed BCD, same packing as a.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port result, output, 4N bits: magnitude |A - B| in packed BCD.
REQ-010 SHALL have port neg, output, 1 bit: sign flag, high when A < B.
REQ-011 SHALL have port invalid, output, 1 bit: high when any captured digit exceeds 9.

Function
REQ-012 SHALL implement an FSM with states IDLE, SUB, FIX and DONE.
REQ-013 SHALL, in IDLE on a clock edge with start=1, register a and b, clear the digit index and result, set carry-in to 1, and go to SUB.
REQ-014 SHALL, in IDLE on a clock edge with start=1 and any digit of a or b > 9, set invalid=1, result=0 and neg=0, and go directly to DONE.
REQ-015 SHALL ignore start in every state except IDLE.
REQ-016 SHALL, in SUB, process one digit per cycle, LSD first.
REQ-017 SHALL compute each SUB digit as s = a_d + (9 - b_d) + c, using a 5-bit intermediate.
REQ-018 SHALL, for each SUB digit with s > 9, store s - 10 and set carry to 1; otherwise store s and set carry to 0.
REQ-019 SHALL, after the Nth SUB digit with final carry = 1, set neg=0 and go to DONE.
REQ-020 SHALL, after the Nth SUB digit with final carry = 0, set neg=1, reset carry-in to 1 and the index to 0, and go to FIX.
REQ-021 SHALL, in FIX, replace each stored digit r_d, LSD first, one per cycle, with the ten's complement digit of (9 - r_d) + c, applying the same >9 correction and carry rule as SUB.
REQ-022 SHALL go from FIX to DONE after the Nth digit.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL assert done N+1 edges after the start edge when A >= B, 2N+1 edges when A < B, and 1 edge for invalid input.
REQ-025 SHALL hold result, neg and invalid stable from DONE until the next accepted start.
REQ-026 SHALL clear invalid on the next accepted start.
REQ-027 SHALL keep result contents undefined to observers while busy=1; only values present at done=1 are specified.
REQ-028 SHALL produce result=0 with neg=0 when A = B (zero is never negative).
REQ-029 SHALL allow a start in the cycle immediately after done, when the FSM is back in IDLE.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, result=0, neg=0, invalid=0, and carry and index to 0, regardless of clk.
REQ-031 SHALL, when reset asserts mid-operation, abandon the operation with no done pulse and resume accepting start on the first edge after rst_n rises.

Verification
REQ-032 SHALL verify (N=4): a=5432, b=1234, start pulse -> done at edge +5, result=4198, neg=0, invalid=0.
REQ-033 SHALL verify: a=1234, b=5432 -> done at edge +9, result=4198, neg=1; and a=0000, b=0001 -> result=0001, neg=1.
REQ-034 SHALL verify: a=7777, b=7777 -> done at +5, result=0000, neg=0; and a=9999, b=0000 -> result=9999, neg=0.
REQ-035 SHALL verify: a=12A4 (hex digit A) -> done at +1, invalid=1, result=0000, neg=0; the next valid start clears invalid.
REQ-036 SHALL verify: start re-pulsed with new operands during SUB -> ignored, and the first result is unchanged.
REQ-037 SHALL verify: rst_n=0 during FIX -> all outputs 0 with no done pulse; a new start after release yields a correct result.
